// File: rtl/ex_operand_hold_pkg.sv
// Shared encodings for the EX-stage operand forward/hold block: hazard flag
// bit positions, ALU operand select codes and the hold FSM states.
package ex_operand_hold_pkg;

  localparam int unsigned FWD_FLAG_W = 3;
  localparam int unsigned ALU_SEL_W  = 2;

  // Bit positions inside forward_detect_EX_rs1/rs2; bit 0 is not a forward source
  localparam int unsigned FORWARD_COLLISION_IN_MEM = 1;
  localparam int unsigned FORWARD_COLLISION_IN_WB  = 2;

  typedef enum logic [ALU_SEL_W-1:0] {
    RS1_SEL_REG      = 2'd0,
    RS1_SEL_PC       = 2'd1,
    RS1_SEL_ZERO     = 2'd2,
    RS1_SEL_ZERO_ALT = 2'd3
  } alu_sel_rs1_e;

  typedef enum logic [ALU_SEL_W-1:0] {
    RS2_SEL_REG     = 2'd0,
    RS2_SEL_IMM     = 2'd1,
    RS2_SEL_LINK    = 2'd2,
    RS2_SEL_IMM_ALT = 2'd3
  } alu_sel_rs2_e;

  typedef enum logic {
    ST_FREE = 1'b0,
    ST_HELD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/operand_forward_lane.sv
// One operand lane: MEM/WB/register-file priority mux plus the hold register
// that freezes the forwarded value while the EX instruction is stalled.
module operand_forward_lane
  import ex_operand_hold_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FWD_FLAG_W-1:0] fwd_flags,
  input  logic [DATA_WIDTH-1:0] rf_val,
  input  logic [DATA_WIDTH-1:0] mem_val,
  input  logic [DATA_WIDTH-1:0] wb_val,
  input  logic                  capture,
  input  logic                  clear,
  input  logic                  use_hold,
  output logic [DATA_WIDTH-1:0] fwd_val
);

  logic [DATA_WIDTH-1:0] live_val;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  unused_flags;

  // The non-forwarding flag bit is part of the bus but carries nothing here
  assign unused_flags = ^fwd_flags;

  // MEM is the younger producer, so it wins over WB
  always_comb begin
    live_val = rf_val;
    if (fwd_flags[FORWARD_COLLISION_IN_MEM]) begin
      live_val = mem_val;
    end else if (fwd_flags[FORWARD_COLLISION_IN_WB]) begin
      live_val = wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (clear) begin
      hold_q <= '0;
    end else if (capture) begin
      hold_q <= live_val;
    end
  end

  assign fwd_val = use_hold ? hold_q : live_val;

endmodule

// File: rtl/ex_operand_hold.sv
// EX-stage operand selection: per-operand forwarding with a hold FSM that keeps
// forwarded values stable across stalls, followed by the ALU source muxes.
module ex_operand_hold
  import ex_operand_hold_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RS2_LINK_CONST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_EX,
  input  logic                  flush_EX,
  input  logic [FWD_FLAG_W-1:0] forward_detect_EX_rs1,
  input  logic [FWD_FLAG_W-1:0] forward_detect_EX_rs2,
  input  logic [DATA_WIDTH-1:0] RD1D_ID_EX_o,
  input  logic [DATA_WIDTH-1:0] RD2D_ID_EX_o,
  input  logic [DATA_WIDTH-1:0] alu_res_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0] result_WB,
  input  logic [DATA_WIDTH-1:0] pc_ID_EX_o,
  input  logic [DATA_WIDTH-1:0] imm_ID_EX_o,
  input  logic [ALU_SEL_W-1:0]  alu_sel_rs1_ID_EX_o,
  input  logic [ALU_SEL_W-1:0]  alu_sel_rs2_ID_EX_o,
  output logic [DATA_WIDTH-1:0] rs1_for_alu_res,
  output logic [DATA_WIDTH-1:0] rs2_for_alu_res,
  output logic [DATA_WIDTH-1:0] rs2_store_data_EX,
  output logic                  operand_held
);

  hold_state_e           state_q;
  hold_state_e           state_d;
  logic                  capture;
  logic                  clear;
  logic                  use_hold;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture on the first stall edge; flush clears and frees from either state
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_FREE: begin
        if (flush_EX) begin
          clear = 1'b1;
        end else if (stall_EX) begin
          capture = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (flush_EX) begin
          clear   = 1'b1;
          state_d = ST_FREE;
        end else if (!stall_EX) begin
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  assign use_hold     = (state_q == ST_HELD);
  assign operand_held = use_hold;

  operand_forward_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_rs1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .fwd_flags(forward_detect_EX_rs1),
    .rf_val   (RD1D_ID_EX_o),
    .mem_val  (alu_res_EX_MEM_o),
    .wb_val   (result_WB),
    .capture  (capture),
    .clear    (clear),
    .use_hold (use_hold),
    .fwd_val  (fwd_rs1)
  );

  operand_forward_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_rs2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .fwd_flags(forward_detect_EX_rs2),
    .rf_val   (RD2D_ID_EX_o),
    .mem_val  (alu_res_EX_MEM_o),
    .wb_val   (result_WB),
    .capture  (capture),
    .clear    (clear),
    .use_hold (use_hold),
    .fwd_val  (fwd_rs2)
  );

  // PC, immediate and link constant bypass the hold path entirely
  always_comb begin
    rs1_for_alu_res = '0;
    case (alu_sel_rs1_e'(alu_sel_rs1_ID_EX_o))
      RS1_SEL_REG:      rs1_for_alu_res = fwd_rs1;
      RS1_SEL_PC:       rs1_for_alu_res = pc_ID_EX_o;
      RS1_SEL_ZERO:     rs1_for_alu_res = '0;
      RS1_SEL_ZERO_ALT: rs1_for_alu_res = '0;
      default:          rs1_for_alu_res = '0;
    endcase
  end

  always_comb begin
    rs2_for_alu_res = fwd_rs2;
    case (alu_sel_rs2_e'(alu_sel_rs2_ID_EX_o))
      RS2_SEL_REG:     rs2_for_alu_res = fwd_rs2;
      RS2_SEL_IMM:     rs2_for_alu_res = imm_ID_EX_o;
      RS2_SEL_LINK:    rs2_for_alu_res = DATA_WIDTH'(RS2_LINK_CONST);
      RS2_SEL_IMM_ALT: rs2_for_alu_res = imm_ID_EX_o;
      default:         rs2_for_alu_res = fwd_rs2;
    endcase
  end

  assign rs2_store_data_EX = fwd_rs2;

endmodule

// File: tb/tb_ex_operand_hold.sv
// Scoreboard bench for ex_operand_hold: directed stimulus pushes expected
// outputs, a monitor pops and compares them at the falling edge.
module tb_ex_operand_hold;
  import ex_operand_hold_pkg::*;

  localparam int unsigned DW = 32;
  localparam logic [FWD_FLAG_W-1:0] F_MEM = FWD_FLAG_W'(1) << FORWARD_COLLISION_IN_MEM;
  localparam logic [FWD_FLAG_W-1:0] F_WB  = FWD_FLAG_W'(1) << FORWARD_COLLISION_IN_WB;

  logic                  clk;
  logic                  rst_n;
  logic                  stall_EX;
  logic                  flush_EX;
  logic [FWD_FLAG_W-1:0] fl1;
  logic [FWD_FLAG_W-1:0] fl2;
  logic [DW-1:0]         rd1, rd2, mem, wb, pc, imm;
  logic [ALU_SEL_W-1:0]  sel1, sel2;
  logic [DW-1:0]         rs1_out, rs2_out, st_out;
  logic                  held_out;

  typedef struct {
    string         tag;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] st;
    logic          held;
    bit            chk_hold;
    logic [DW-1:0] h1;
    logic [DW-1:0] h2;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_operand_hold #(.DATA_WIDTH(DW), .RS2_LINK_CONST(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall_EX             (stall_EX),
    .flush_EX             (flush_EX),
    .forward_detect_EX_rs1(fl1),
    .forward_detect_EX_rs2(fl2),
    .RD1D_ID_EX_o         (rd1),
    .RD2D_ID_EX_o         (rd2),
    .alu_res_EX_MEM_o     (mem),
    .result_WB            (wb),
    .pc_ID_EX_o           (pc),
    .imm_ID_EX_o          (imm),
    .alu_sel_rs1_ID_EX_o  (sel1),
    .alu_sel_rs2_ID_EX_o  (sel2),
    .rs1_for_alu_res      (rs1_out),
    .rs2_for_alu_res      (rs2_out),
    .rs2_store_data_EX    (st_out),
    .operand_held         (held_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input string field,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every pending expectation is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, "rs1", rs1_out, e.rs1);
        check(e.tag, "rs2", rs2_out, e.rs2);
        check(e.tag, "store", st_out, e.st);
        check(e.tag, "held", DW'(held_out), DW'(e.held));
        if (e.chk_hold) begin
          check(e.tag, "hold1", dut.u_lane_rs1.hold_q, e.h1);
          check(e.tag, "hold2", dut.u_lane_rs2.hold_q, e.h2);
        end
      end
    end
  end

  task automatic expect_out(input string tag, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                            input logic [DW-1:0] st, input logic held);
    exp_t e;
    e.tag = tag; e.rs1 = r1; e.rs2 = r2; e.st = st; e.held = held;
    e.chk_hold = 1'b0; e.h1 = '0; e.h2 = '0;
    sb.push_back(e);
  endtask

  task automatic expect_hold(input string tag, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                             input logic [DW-1:0] st, input logic held,
                             input logic [DW-1:0] h1, input logic [DW-1:0] h2);
    exp_t e;
    e.tag = tag; e.rs1 = r1; e.rs2 = r2; e.st = st; e.held = held;
    e.chk_hold = 1'b1; e.h1 = h1; e.h2 = h2;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_EX = 1'b0; flush_EX = 1'b0;
    fl1 = '0; fl2 = '0; rd1 = '0; rd2 = '0; mem = '0; wb = '0; pc = '0; imm = '0;
    sel1 = '0; sel2 = '0;
    #3;
    // In reset: FREE mux on outputs, stall ignored
    rd1 = 32'h12; rd2 = 32'h34; stall_EX = 1'b1;
    expect_hold("reset", 32'h12, 32'h34, 32'h34, 1'b0, 32'h0, 32'h0);
    #10;
    rst_n = 1'b1; stall_EX = 1'b0;

    // Forwarding priority
    step(); fl2 = F_MEM | F_WB; mem = 32'h11; wb = 32'h22; rd2 = 32'h99;
    expect_out("mem_wins", 32'h12, 32'h11, 32'h11, 1'b0);
    step(); fl2 = F_WB;
    expect_out("wb_only", 32'h12, 32'h22, 32'h22, 1'b0);
    step(); fl2 = 3'b001;
    expect_out("ignored_bit", 32'h12, 32'h99, 32'h99, 1'b0);
    step(); fl1 = F_MEM; fl2 = '0;
    expect_out("rs1_mem", 32'h11, 32'h99, 32'h99, 1'b0);

    // Three-cycle stall with WB source changing underneath
    step(); fl1 = F_WB; wb = 32'hAB; rd1 = 32'h77; rd2 = 32'h66; stall_EX = 1'b1;
    expect_hold("stall_c1", 32'hAB, 32'h66, 32'h66, 1'b0, 32'h0, 32'h0);
    step(); wb = 32'hCD; rd2 = 32'h67;
    expect_hold("stall_c2", 32'hAB, 32'h66, 32'h66, 1'b1, 32'hAB, 32'h66);
    step();
    expect_out("stall_c3", 32'hAB, 32'h66, 32'h66, 1'b1);
    step(); stall_EX = 1'b0;
    expect_out("release", 32'hAB, 32'h66, 32'h66, 1'b1);
    step();
    expect_out("free_live", 32'hCD, 32'h67, 32'h67, 1'b0);

    // PC/immediate bypass hold; flush+stall in HELD
    step(); fl1 = '0; rd1 = 32'h200; rd2 = 32'h300; stall_EX = 1'b1;
    expect_out("pc_c1", 32'h200, 32'h300, 32'h300, 1'b0);
    step(); sel1 = 2'd1; pc = 32'h100; sel2 = 2'd1; imm = 32'h5A; rd1 = 32'h201; rd2 = 32'h301;
    expect_hold("pc_held", 32'h100, 32'h5A, 32'h300, 1'b1, 32'h200, 32'h300);
    step(); pc = 32'h104; imm = 32'h5B; sel2 = 2'd3;
    expect_out("pc_follow", 32'h104, 32'h5B, 32'h300, 1'b1);
    step(); sel1 = 2'd0; sel2 = 2'd0; flush_EX = 1'b1;
    expect_out("flush_cyc", 32'h200, 32'h300, 32'h300, 1'b1);
    step(); flush_EX = 1'b0; stall_EX = 1'b0;
    expect_hold("after_flush", 32'h201, 32'h301, 32'h301, 1'b0, 32'h0, 32'h0);

    // Link constant and zero selects
    step(); sel2 = 2'd2; rd2 = 32'h55;
    expect_out("link", 32'h201, 32'h4, 32'h55, 1'b0);
    step(); sel1 = 2'd2;
    expect_out("rs1_zero2", 32'h0, 32'h4, 32'h55, 1'b0);
    step(); sel1 = 2'd3;
    expect_out("rs1_zero3", 32'h0, 32'h4, 32'h55, 1'b0);

    // Flush beats stall from FREE
    step(); sel1 = '0; sel2 = '0; flush_EX = 1'b1; stall_EX = 1'b1; rd1 = 32'h3A;
    expect_hold("flush_free", 32'h3A, 32'h55, 32'h55, 1'b0, 32'h0, 32'h0);
    step(); flush_EX = 1'b0; stall_EX = 1'b0;
    expect_hold("flush_free2", 32'h3A, 32'h55, 32'h55, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-HELD
    step(); stall_EX = 1'b1; rd1 = 32'hAA1;
    expect_out("rst_c1", 32'hAA1, 32'h55, 32'h55, 1'b0);
    step(); rd1 = 32'hAA2;
    expect_hold("rst_held", 32'hAA1, 32'h55, 32'h55, 1'b1, 32'hAA1, 32'h55);
    step(); #1;
    rst_n = 1'b0; stall_EX = 1'b0; rd1 = 32'hBEEF;
    #1;
    expect_hold("rst_async", 32'hBEEF, 32'h55, 32'h55, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(); rd1 = 32'hBEF0;
    expect_hold("rst_after", 32'hBEF0, 32'h55, 32'h55, 1'b0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_hold.md
EX_OPERAND_HOLD -- requirements
Module: ex_operand_hold

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every data port and hold register.
REQ-002 Parameter RS2_LINK_CONST, default 4, constant selected by alu_sel_rs2 = 2 (link address increment).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall_EX  input  1  EX instruction held in place this cycle.
REQ-006 flush_EX  input  1  EX instruction squashed this cycle.
REQ-007 forward_detect_EX_rs1 / forward_detect_EX_rs2  input  3 each  hazard flags, bit positions FORWARD_COLLISION_IN_MEM and FORWARD_COLLISION_IN_WB, remaining bit ignored.
REQ-008 RD1D_ID_EX_o / RD2D_ID_EX_o  input  DATA_WIDTH  register-file operands from the ID/EX register.
REQ-009 alu_res_EX_MEM_o, result_WB  input  DATA_WIDTH  MEM-stage and WB-stage forwarding sources.
REQ-010 pc_ID_EX_o, imm_ID_EX_o  input  DATA_WIDTH  PC and immediate of the EX instruction.
REQ-011 alu_sel_rs1_ID_EX_o / alu_sel_rs2_ID_EX_o  input  2 each  ALU operand source selects.
REQ-012 rs1_for_alu_res / rs2_for_alu_res  output  DATA_WIDTH  ALU operands.
REQ-013 rs2_store_data_EX  output  DATA_WIDTH  forwarded rs2 before the immediate mux (store data).
REQ-014 operand_held  output  1  high while operands come from the hold registers.

Function
REQ-015 Live forward value per operand: MEM source if its MEM flag is set, else WB source if its WB flag is set, else the register-file value; MEM wins when both flags are set.
REQ-016 The FSM shall have two states: FREE and HELD.
REQ-017 In FREE, the forwarded operand shall be the live value, combinational, zero latency.
REQ-018 FREE with stall_EX=1 and flush_EX=0 at a rising edge: both live values captured into hold registers, next state HELD.
REQ-019 In HELD, the forwarded operand shall be the hold register, ignoring flags and the MEM/WB sources.
REQ-020 HELD with stall_EX=1 and flush_EX=0: stays HELD, hold registers unchanged.
REQ-021 HELD with stall_EX=0: next state FREE, hold registers unchanged.
REQ-022 flush_EX=1 in any state: next state FREE and hold registers cleared to 0, taking priority over stall_EX.
REQ-023 The first stall cycle shall present live values; held values appear from the second stall cycle on.
REQ-024 rs1_for_alu_res selection: 0 forwarded rs1, 1 pc_ID_EX_o, 2 and 3 all zeros.
REQ-025 rs2_for_alu_res selection: 0 forwarded rs2, 1 and 3 imm_ID_EX_o, 2 RS2_LINK_CONST zero-extended to DATA_WIDTH.
REQ-026 The PC and immediate paths shall never be held; only the forwarded register operands shall be held.
REQ-027 rs2_store_data_EX shall equal forwarded rs2 regardless of alu_sel_rs2_ID_EX_o.
REQ-028 operand_held shall be 1 exactly when the state is HELD.

Reset
REQ-029 rst_n low shall asynchronously force state FREE, hold registers 0 and operand_held 0.
REQ-030 While in reset, data outputs shall follow the FREE-state combinational mux.
REQ-031 Reset asserted mid-stall shall discard held values; after release, operands are live.

Structure
REQ-032 A shared package shall hold FORWARD_COLLISION_IN_MEM/IN_WB bit indices, alu_sel encodings and the FREE/HELD state encoding.
REQ-033 A sub-module operand_forward_lane shall hold one operand's priority mux and hold register; it shall be instantiated twice, with the FSM in the parent.

Verification
REQ-034 Scenario: rs2 flags MEM+WB set, MEM=0x11, WB=0x22, sel=0 -> rs2_for_alu_res=0x11.
REQ-035 Scenario: WB flag on rs1 with WB=0xAB; stall_EX high 3 cycles while WB changes to 0xCD -> cycle 1 output 0xAB live, cycles 2-3 0xAB held with operand_held=1, output live after stall drops.
REQ-036 Scenario: flush_EX=1 together with stall_EX=1 in HELD -> next cycle operand_held=0, hold registers 0.
REQ-037 Scenario: alu_sel_rs2=2, RD2=0x55 -> rs2_for_alu_res=0x4, rs2_store_data_EX=0x55.
REQ-038 Scenario: alu_sel_rs1=1, pc=0x100 during HELD -> rs1_for_alu_res=0x100, follows pc changes.
REQ-039 Scenario: rst_n pulsed low mid-HELD between clock edges -> operand_held=0 immediately, live values on outputs.
